// File: rtl/pc_fetch_sequencer.sv
// Program-counter owner and fetch/execute sequencer: requests an instruction at pc,
// hands it to the datapath, then advances pc (sequential or branch) once execution is done.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        halt,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        branch,
    input  logic        uncondbranch,
    input  logic        zero,
    input  logic [31:0] sign_extend,
    output logic [31:0] pc,
    output logic [31:0] retired,
    output logic        busy,
    output logic        halted,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALTED,
        S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] retired_q, retired_d;
    logic [31:0] wd_q, wd_d;
    logic        instr_valid_q, instr_valid_d;
    logic        halt_q, halt_d;
    logic        take;
    logic        wdExpired;

    assign take      = uncondbranch | (branch & zero);
    // The watchdog fires on the last allowed FETCH cycle; an ack in that same cycle still wins.
    assign wdExpired = (TIMEOUT != 0) && (wd_q == TIMEOUT - 32'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = halt ? S_HALTED : S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_ack) begin
                    state_d = S_EXEC;
                end else if (wdExpired) begin
                    state_d = S_ERR;
                end
            end
            S_EXEC: begin
                if (exec_done) begin
                    state_d = (halt || halt_q) ? S_HALTED : S_FETCH;
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_comb begin
        imem_req = (state_q == S_FETCH);
        busy     = (state_q == S_FETCH) || (state_q == S_EXEC);
        halted   = (state_q == S_HALTED);
        err      = (state_q == S_ERR);
    end

    always_comb begin
        pc_d          = pc_q;
        instr_d       = instr_q;
        retired_d     = retired_q;
        wd_d          = 32'd0;
        instr_valid_d = 1'b0;
        halt_d        = halt_q;
        if (busy && halt) begin
            halt_d = 1'b1;
        end
        if (state_q == S_FETCH) begin
            if (imem_ack) begin
                instr_d       = imem_rdata;
                instr_valid_d = 1'b1;
            end else if (TIMEOUT != 0) begin
                wd_d = wd_q + 32'd1;
            end
        end
        // Offsets are word counts; the shift and both sums wrap modulo 2^32 by design.
        if ((state_q == S_EXEC) && exec_done) begin
            pc_d      = take ? pc_q + (sign_extend << 2) : pc_q + 32'd4;
            retired_d = retired_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            instr_q       <= 32'd0;
            retired_q     <= 32'd0;
            wd_q          <= 32'd0;
            instr_valid_q <= 1'b0;
            halt_q        <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            retired_q     <= retired_d;
            wd_q          <= wd_d;
            instr_valid_q <= instr_valid_d;
            halt_q        <= halt_d;
        end
    end

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: directed and randomized fetch/execute
// transactions checked against a transaction-level model of pc, retired count and instr.
module tb_pc_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, halt, imem_ack, exec_done;
    logic        branch, uncondbranch, zero;
    logic [31:0] imem_rdata, sign_extend;
    logic        imem_req, instr_valid, busy, halted, err;
    logic [31:0] imem_addr, instr, pc, retired;

    int          nChecks = 0;
    int          nFails  = 0;
    logic [31:0] mPc, mRet, mInstr;
    logic        mHaltPending;

    pc_fetch_sequencer #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .start(start), .halt(halt),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
        .exec_done(exec_done), .branch(branch), .uncondbranch(uncondbranch),
        .zero(zero), .sign_extend(sign_extend), .pc(pc), .retired(retired),
        .busy(busy), .halted(halted), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clearInputs();
        start = 0; halt = 0; imem_ack = 0; exec_done = 0;
        branch = 0; uncondbranch = 0; zero = 0;
        imem_rdata = 32'd0; sign_extend = 32'd0;
    endtask

    task automatic resetDut();
        clearInputs();
        reset = 1;
        tick();
        reset = 0;
        mPc = 32'd0; mRet = 32'd0; mInstr = 32'd0; mHaltPending = 0;
        check("rst_pc", pc, mPc);
        check("rst_retired", retired, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_req", imem_req, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_err", err, 1'b0);
    endtask

    task automatic startRun();
        start = 1;
        tick();
        start = 0;
        check("start_busy", busy, 1'b1);
    endtask

    // Called in the first FETCH cycle; acks after 'delay' waiting cycles.
    task automatic doFetch(input int delay, input logic [31:0] data, input logic haltPulse);
        for (int i = 0; i < delay; i++) begin
            check("fetch_req", imem_req, 1'b1);
            check("fetch_addr", imem_addr, mPc);
            exec_done = $urandom_range(0, 1);
            halt = haltPulse && (i == 0);
            tick();
            exec_done = 0; halt = 0;
            check("fetch_pc_hold", pc, mPc);
        end
        check("ack_req", imem_req, 1'b1);
        imem_ack = 1; imem_rdata = data;
        halt = haltPulse && (delay == 0);
        tick();
        imem_ack = 0; halt = 0;
        if (haltPulse) mHaltPending = 1;
        mInstr = data;
        check("instr", instr, data);
        check("instr_valid", instr_valid, 1'b1);
        check("exec_busy", busy, 1'b1);
        check("exec_req", imem_req, 1'b0);
    endtask

    // Called in the first EXEC cycle; completes after 'waitCycles' idle cycles.
    task automatic doExec(input int waitCycles, input logic br, input logic ub, input logic z,
                          input logic [31:0] se, input logic haltNow);
        logic expHalt;
        for (int i = 0; i < waitCycles; i++) begin
            imem_ack = 1; imem_rdata = $urandom;
            tick();
            imem_ack = 0;
            check("exec_instr_hold", instr, mInstr);
            check("valid_pulse", instr_valid, 1'b0);
            check("exec_pc_hold", pc, mPc);
        end
        exec_done = 1; branch = br; uncondbranch = ub; zero = z; sign_extend = se; halt = haltNow;
        tick();
        clearInputs();
        mPc  = (ub || (br && z)) ? mPc + se * 4 : mPc + 32'd4;
        mRet = mRet + 32'd1;
        expHalt = haltNow || mHaltPending;
        check("next_pc", pc, mPc);
        check("retired", retired, mRet);
        check("halted_after_exec", halted, expHalt);
        check("req_after_exec", imem_req, !expHalt);
        if (!expHalt) check("addr_after_exec", imem_addr, mPc);
    endtask

    initial begin
        logic [31:0] se;
        reset = 0;
        clearInputs();

        resetDut();
        imem_ack = 1; imem_rdata = 32'h1234_5678;
        tick();
        imem_ack = 0;
        check("idle_ack_ignored", instr, 32'd0);
        startRun();
        doFetch(2, 32'hDEAD_BEEF, 0);
        doExec(1, 0, 0, 0, 32'd0, 0);
        check("seq_pc_4", pc, 32'h4);
        doFetch(0, $urandom, 0);
        doExec(0, 1, 0, 1, 32'd3, 0);
        check("taken_pc_10", pc, 32'h10);
        doFetch(1, $urandom, 0);
        doExec(2, 1, 0, 0, 32'd3, 0);
        doFetch(0, $urandom, 0);
        doExec(0, 0, 1, 0, 32'hFFFF_FFFE, 0);
        doFetch(0, $urandom, 0);
        se = (32'hFFFF_FFFC - mPc) >> 2;
        doExec(1, 0, 1, 0, se, 0);
        check("pc_top", pc, 32'hFFFF_FFFC);
        doFetch(1, $urandom, 0);
        doExec(0, 0, 0, 0, 32'd0, 0);
        check("pc_wrap", pc, 32'h0);

        for (int n = 0; n < 20; n++) begin
            doFetch($urandom_range(0, 6), $urandom, 0);
            se = $urandom_range(0, 64);
            se = se - 32'd32;
            doExec($urandom_range(0, 4), 1'($urandom), 1'($urandom), 1'($urandom), se, 0);
        end

        doFetch(3, $urandom, 1);
        doExec(1, 0, 0, 0, 32'd0, 0);
        for (int i = 0; i < 4; i++) begin
            start = 1; imem_ack = 1; exec_done = 1; branch = 1; zero = 1;
            tick();
            clearInputs();
            check("halt_req", imem_req, 1'b0);
            check("halt_pc", pc, mPc);
            check("halt_retired", retired, mRet);
            check("halt_state", halted, 1'b1);
        end

        resetDut();
        startRun();
        for (int i = 0; i < 16; i++) begin
            check("wd_req", imem_req, 1'b1);
            tick();
        end
        check("wd_err", err, 1'b1);
        check("wd_req_off", imem_req, 1'b0);
        check("wd_not_busy", busy, 1'b0);
        imem_ack = 1; start = 1;
        tick();
        clearInputs();
        check("err_sticky", err, 1'b1);

        resetDut();
        startRun();
        doFetch(15, 32'hCAFE_F00D, 0);
        check("late_ack_no_err", err, 1'b0);
        doExec(0, 0, 0, 0, 32'd0, 0);

        resetDut();
        start = 1; halt = 1;
        tick();
        clearInputs();
        check("idle_halt_wins", halted, 1'b1);
        check("idle_halt_req", imem_req, 1'b0);

        resetDut();
        startRun();
        doFetch(1, 32'hA5A5_A5A5, 0);
        exec_done = 1; uncondbranch = 1; sign_extend = 32'd8; reset = 1;
        tick();
        clearInputs();
        reset = 0;
        check("rst_exec_pc", pc, 32'd0);
        check("rst_exec_retired", retired, 32'd0);
        check("rst_exec_busy", busy, 1'b0);
        check("rst_exec_instr", instr, 32'd0);
        tick();
        check("rst_exec_idle", imem_req, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
